pollard_sequencer: RTL and testbench
====================================

Name: pollard_sequencer

Overview:
Control FSM for stage 1 of Pollard p-1. Walks a prime table and, for each prime p <= boundary, asks exponent_finder for the largest e with p^e <= boundary. It then issues e back-to-back "a = a^p mod n" commands to the modular-power unit. Sits between the top-level start/boundary registers, the prime ROM, exponent_finder and the modexp datapath.

Parameters:
ADDR_W, 6, prime table address width (table depth 2^ADDR_W entries)
TIMEOUT, 255, handshake watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; accepted only in IDLE
boundary  input  8  smoothness bound B; captured on accepted start
prime_addr  output  ADDR_W  prime ROM address
prime_data  input  9  ROM data, valid 1 cycle after prime_addr; value 0 = end-of-table sentinel
ef_input_enable  output  1  exponent_finder request, level
ef_base  output  9  current prime to exponent_finder
ef_boundary  output  8  captured boundary to exponent_finder
ef_exponent  input  8  exponent result, valid while ef_ready high
ef_ready  input  1  exponent_finder result valid
mx_start  output  1  one-cycle pulse: perform a = a^mx_power mod n
mx_power  output  9  current prime
mx_done  input  1  one-cycle pulse from modexp when operation complete
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when sequence completes
primes_done  output  ADDR_W+1  count of primes whose powers were fully applied
error  output  1  watchdog expiry flag (0 without SEQ_TIMEOUT_EN)

Behaviour:
- Reset (async): state IDLE. prime_addr, ef_input_enable, ef_base, ef_boundary, mx_start, mx_power, busy, done, primes_done and error all go to 0.
- States: IDLE, FETCH, LOAD, CHECK, FIND, POWER, WAIT_MX, DONE.
- IDLE: on start, capture boundary, clear primes_done and error, set prime_addr=0, go to FETCH. start is ignored in all other states.
- FETCH: one cycle of ROM latency, then LOAD.
- LOAD: register prime_data into ef_base and mx_power, then CHECK.
- CHECK: if prime is 0 or prime > captured boundary, go to DONE (unsigned compare; 9-bit prime vs zero-extended boundary). Otherwise go to FIND.
- FIND: ef_input_enable high from the first FIND cycle. It is held until ef_ready is sampled high. That cycle: latch ef_exponent into internal count, drop ef_input_enable (low at least 1 cycle).
  - count == 0 -> advance.
  - otherwise -> POWER.
- POWER: mx_start high exactly one cycle, then WAIT_MX.
- WAIT_MX: wait for mx_done. On mx_done, decrement count.
  - count != 0 -> POWER (the next mx_start comes 1 cycle after mx_done).
  - count == 0 -> increment primes_done, advance.
- mx_done seen outside WAIT_MX is ignored.
- advance: if prime_addr == 2^ADDR_W-1, go to DONE (no wrap). Otherwise prime_addr+1 and go to FETCH.
- DONE: done high exactly one cycle, then IDLE. primes_done holds its value until the next accepted start.
- Reset mid-operation: immediate return to IDLE. Any in-flight modexp/exponent_finder result arriving afterwards is ignored.
- Latency per prime: 3 cycles (FETCH, LOAD, CHECK) + finder time + e × (1 + modexp time + 0).

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: an 8-bit watchdog counts cycles spent in FIND or WAIT_MX and clears on each state entry. On reaching TIMEOUT, error is set, ef_input_enable drops, and the FSM goes to DONE (done pulses). error stays high until reset or the next accepted start.
- Undefined: no counter is built, error is tied to 0, and waits are unbounded.

Test Plan:
- ROM {2,3,5,7,11,0}, boundary=10, finder model returns 3,2,1,1: mx_start pulses with mx_power 2,2,2,3,3,5,7 (7 total); 11 is rejected in CHECK; done pulses once; primes_done=4.
- boundary=1, ROM {2,...}: no ef_input_enable and no mx_start; done pulses 4 cycles after start; primes_done=0.
- ROM {0}: done with primes_done=0, no finder requests.
- Finder returns exponent 0 for prime 3 (ROM {2,3,0}, boundary=10): no mx_start with power 3; primes_done=1.
- Assert reset during 2nd WAIT_MX, then pulse mx_done: all outputs 0, state IDLE, no further mx_start; a new start restarts from prime_addr=0.
- With SEQ_TIMEOUT_EN, TIMEOUT=20, mx_done never returns: error=1 and done pulses 20 cycles after entering WAIT_MX. Without the macro, error stays 0 and busy stays 1.

Source files
------------

// File: rtl/pollard_sequencer_if.sv
// Handshake bundle between pollard_sequencer and its environment: start/boundary registers,
// prime ROM, exponent_finder, modexp datapath, plus status and a debug view of the FSM state.
interface pollard_sequencer_if #(
  parameter int ADDR_W = 6
);
  // Handshakes: ef_input_enable is a level request held until ef_ready is sampled high, and
  // ef_exponent is valid only in that cycle. mx_start and mx_done are single-cycle pulses.
  // start is a single-cycle pulse. The ROM answers prime_addr with prime_data one cycle later.
  logic              start;
  logic [7:0]        boundary;
  logic [ADDR_W-1:0] prime_addr;
  logic [8:0]        prime_data;
  logic              ef_input_enable;
  logic [8:0]        ef_base;
  logic [7:0]        ef_boundary;
  logic [7:0]        ef_exponent;
  logic              ef_ready;
  logic              mx_start;
  logic [8:0]        mx_power;
  logic              mx_done;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   primes_done;
  logic              error;
  logic [2:0]        dbg_state;

  modport master (
    input  start, boundary, prime_data, ef_exponent, ef_ready, mx_done,
    output prime_addr, ef_input_enable, ef_base, ef_boundary, mx_start, mx_power,
           busy, done, primes_done, error, dbg_state
  );

  modport slave (
    output start, boundary, prime_data, ef_exponent, ef_ready, mx_done,
    input  prime_addr, ef_input_enable, ef_base, ef_boundary, mx_start, mx_power,
           busy, done, primes_done, error, dbg_state
  );
endinterface

// File: rtl/pollard_sequencer.sv
// Stage-1 Pollard p-1 sequencer: walks the prime table, asks exponent_finder for e, issues e modexp ops.
// Define SEQ_TIMEOUT_EN to add a watchdog on the FIND and WAIT_MX waits that raises error.
module pollard_sequencer #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  pollard_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    CHECK   = 3'd3,
    FIND    = 3'd4,
    POWER   = 3'd5,
    WAIT_MX = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t     state;
  logic [7:0] count;
  logic       at_last;
  logic       reject;
  logic       advance;

  assign bus.dbg_state = state;
  assign at_last       = (bus.prime_addr == LAST_ADDR);
  assign reject        = (bus.ef_base == 9'd0) || (bus.ef_base > {1'b0, bus.ef_boundary});

  // A prime is finished either with a zero exponent or after its last modexp completes.
  assign advance = ((state == FIND) && bus.ef_ready && (bus.ef_exponent == 8'd0)) ||
                   ((state == WAIT_MX) && bus.mx_done && (count == 8'd1));

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd;
  logic       wd_expired;
  assign wd_expired = (wd == WD_LAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      count               <= '0;
      bus.prime_addr      <= '0;
      bus.ef_input_enable <= 1'b0;
      bus.ef_base         <= '0;
      bus.ef_boundary     <= '0;
      bus.mx_start        <= 1'b0;
      bus.mx_power        <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.primes_done     <= '0;
      bus.error           <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd                  <= '0;
`endif
    end else begin
      bus.mx_start <= 1'b0;
      bus.done     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      // Only FIND and WAIT_MX count; every other state parks the watchdog at zero.
      wd <= '0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.ef_boundary <= bus.boundary;
            bus.primes_done <= '0;
            bus.error       <= 1'b0;
            bus.prime_addr  <= '0;
            bus.busy        <= 1'b1;
            state           <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          bus.ef_base  <= bus.prime_data;
          bus.mx_power <= bus.prime_data;
          state        <= CHECK;
        end
        CHECK: begin
          if (reject) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            bus.ef_input_enable <= 1'b1;
            state               <= FIND;
          end
        end
        FIND: begin
          if (bus.ef_ready) begin
            bus.ef_input_enable <= 1'b0;
            count               <= bus.ef_exponent;
            if (bus.ef_exponent != 8'd0) begin
              bus.mx_start <= 1'b1;
              state        <= POWER;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            bus.ef_input_enable <= 1'b0;
            bus.error           <= 1'b1;
            bus.done            <= 1'b1;
            state               <= DONE;
          end else begin
            wd <= wd + 8'd1;
          end
`endif
        end
        POWER: state <= WAIT_MX;
        WAIT_MX: begin
          if (bus.mx_done) begin
            count <= count - 8'd1;
            if (count != 8'd1) begin
              bus.mx_start <= 1'b1;
              state        <= POWER;
            end else begin
              bus.primes_done <= bus.primes_done + 1'b1;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            bus.error <= 1'b1;
            bus.done  <= 1'b1;
            state     <= DONE;
          end else begin
            wd <= wd + 8'd1;
          end
`endif
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The table never wraps: the last entry ends the sequence.
      if (advance) begin
        if (at_last) begin
          bus.done <= 1'b1;
          state    <= DONE;
        end else begin
          bus.prime_addr <= bus.prime_addr + 1'b1;
          state          <= FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_pollard_sequencer.sv
// Bench for pollard_sequencer: table vectors, randomized runs against a reference model,
// and hand-written reset / watchdog sequences.
module tb_pollard_sequencer;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 20;
  localparam int DEPTH   = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pollard_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  pollard_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- environment models ----------------
  logic [8:0] rom [DEPTH];
  int         f_exp [DEPTH];
  bit         use_math;
  int         ef_lat, mx_lat;
  bit         mx_hang, inject_mx;
  int         ef_cnt, mx_cnt;
  bit         mx_pend;

  // Largest e with p^e <= b, straight from the definition.
  function automatic int true_exp(int p, int b);
    int e = 0;
    int v = p;
    while (v <= b) begin
      e++;
      v = v * p;
    end
    return e;
  endfunction

  always @(posedge clk) bus.prime_data <= rom[bus.prime_addr];

  always @(posedge clk) begin
    if (reset) begin
      bus.ef_ready <= 1'b0;
      ef_cnt       <= 0;
    end else if (bus.ef_input_enable && !bus.ef_ready) begin
      if (ef_cnt >= ef_lat) begin
        bus.ef_ready    <= 1'b1;
        bus.ef_exponent <= 8'(use_math ? true_exp(int'(bus.ef_base), int'(bus.ef_boundary))
                                       : f_exp[bus.prime_addr]);
        ef_cnt          <= 0;
      end else begin
        ef_cnt <= ef_cnt + 1;
      end
    end else begin
      bus.ef_ready <= 1'b0;
    end
  end

  always @(posedge clk) begin
    bus.mx_done <= inject_mx;
    if (reset) begin
      mx_pend <= 1'b0;
    end else if (bus.mx_start) begin
      mx_pend <= 1'b1;
      mx_cnt  <= mx_lat;
    end else if (mx_pend && !mx_hang) begin
      if (mx_cnt == 0) begin
        bus.mx_done <= 1'b1;
        mx_pend     <= 1'b0;
      end else begin
        mx_cnt <= mx_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] ef_q[$];
  int         cur_b;
  int         mx_seen, ef_seen, done_seen;
  bit         ef_prev;

  always @(negedge clk) begin
    if (reset) begin
      ef_prev = 1'b0;
    end else begin
      if (bus.mx_start) begin
        mx_seen++;
        check("mx_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("mx_power", bus.mx_power, exp_q.pop_front());
      end
      if (bus.ef_input_enable && !ef_prev) begin
        ef_seen++;
        check("ef_q_nonempty", ef_q.size() > 0, 1);
        if (ef_q.size() > 0) check("ef_base", bus.ef_base, ef_q.pop_front());
        check("ef_boundary", bus.ef_boundary, cur_b);
      end
      ef_prev = bus.ef_input_enable;
      if (bus.done) done_seen++;
    end
  end

  // Reference: walk the table until sentinel, oversized prime or end of table.
  task automatic build_expect(input int b, output int pd, output int nef, output int nmx);
    exp_q.delete();
    ef_q.delete();
    pd    = 0;
    nef   = 0;
    cur_b = b;
    for (int a = 0; a < DEPTH; a++) begin
      int p, e;
      p = int'(rom[a]);
      if (p == 0 || p > b) break;
      e = use_math ? true_exp(p, b) : f_exp[a];
      ef_q.push_back(9'(p));
      nef++;
      for (int k = 0; k < e; k++) exp_q.push_back(9'(p));
      if (e > 0) pd++;
    end
    nmx = exp_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_seq(input logic [7:0] b, input bit poke_start, output int cyc);
    mx_seen   = 0;
    ef_seen   = 0;
    done_seen = 0;
    @(negedge clk);
    bus.boundary = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("fetch_addr_zero", bus.prime_addr, 0);
    check("busy_after_start", bus.busy, 1);
    while (!bus.done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (poke_start && cyc == 6) begin
        bus.start    = 1'b1;
        bus.boundary = ~b;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("done_within_budget", bus.done, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic verify_run(string tag, int pd, int nef, int nmx);
    check({tag, "_mx_count"}, mx_seen, nmx);
    check({tag, "_ef_count"}, ef_seen, nef);
    check({tag, "_done_once"}, done_seen, 1);
    check({tag, "_primes_done"}, bus.primes_done, pd);
    check({tag, "_busy_idle"}, bus.busy, 0);
    check({tag, "_error"}, bus.error, 0);
    check({tag, "_q_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_prime_addr"}, bus.prime_addr, 0);
    check({tag, "_ef_en"}, bus.ef_input_enable, 0);
    check({tag, "_ef_base"}, bus.ef_base, 0);
    check({tag, "_ef_boundary"}, bus.ef_boundary, 0);
    check({tag, "_mx_start"}, bus.mx_start, 0);
    check({tag, "_mx_power"}, bus.mx_power, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_primes_done"}, bus.primes_done, 0);
    check({tag, "_error"}, bus.error, 0);
    check({tag, "_state_idle"}, bus.dbg_state, 0);
  endtask

  typedef struct packed {
    logic [0:7][8:0] rom;
    logic [0:7][7:0] fexp;
    logic [7:0]      b;
    logic [7:0]      exp_mx;
    logic [7:0]      exp_pd;
    logic [7:0]      exp_ef;
    logic [7:0]      exp_cyc;   // 0: latency not checked
  } vec_t;

  vec_t vecs[7];

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < DEPTH; i++) begin
      rom[i]   = '0;
      f_exp[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      rom[i]   = v.rom[i];
      f_exp[i] = int'(v.fexp[i]);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int pd, nef, nmx, cyc, n;

    vecs[0] = '{rom: {9'd2, 9'd3, 9'd5, 9'd7, 9'd11, 9'd0, 9'd0, 9'd0},
                fexp: {8'd3, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
                b: 8'd10, exp_mx: 8'd7, exp_pd: 8'd4, exp_ef: 8'd4, exp_cyc: 8'd0};
    vecs[1] = '{rom: {9'd2, 9'd3, 9'd5, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                fexp: {8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                b: 8'd1, exp_mx: 8'd0, exp_pd: 8'd0, exp_ef: 8'd0, exp_cyc: 8'd4};
    vecs[2] = '{rom: {9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                fexp: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                b: 8'd50, exp_mx: 8'd0, exp_pd: 8'd0, exp_ef: 8'd0, exp_cyc: 8'd4};
    vecs[3] = '{rom: {9'd2, 9'd3, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                fexp: {8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                b: 8'd10, exp_mx: 8'd3, exp_pd: 8'd1, exp_ef: 8'd2, exp_cyc: 8'd0};
    vecs[4] = '{rom: {9'd2, 9'd3, 9'd5, 9'd7, 9'd11, 9'd0, 9'd0, 9'd0},
                fexp: {8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
                b: 8'd7, exp_mx: 8'd5, exp_pd: 8'd4, exp_ef: 8'd4, exp_cyc: 8'd0};
    vecs[5] = '{rom: {9'd2, 9'd256, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                fexp: {8'd7, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                b: 8'd255, exp_mx: 8'd7, exp_pd: 8'd1, exp_ef: 8'd1, exp_cyc: 8'd0};
    vecs[6] = '{rom: {9'd2, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0},
                fexp: {8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                b: 8'd10, exp_mx: 8'd2, exp_pd: 8'd1, exp_ef: 8'd1, exp_cyc: 8'd15};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.boundary = '0;
    use_math     = 1'b0;
    ef_lat       = 0;
    mx_lat       = 0;
    mx_hang      = 1'b0;
    inject_mx    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rom[i]   = '0;
      f_exp[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Table-driven vectors, fixed zero-latency finder and modexp.
    for (int i = 0; i < 7; i++) begin
      load_vec(vecs[i]);
      build_expect(int'(vecs[i].b), pd, nef, nmx);
      run_seq(vecs[i].b, 1'b1, cyc);
      verify_run($sformatf("vec%0d", i), int'(vecs[i].exp_pd), int'(vecs[i].exp_ef),
                 int'(vecs[i].exp_mx));
      if (vecs[i].exp_cyc != 0) check($sformatf("vec%0d_cycles", i), cyc, int'(vecs[i].exp_cyc));
    end

    // Randomized tables, latencies and boundaries against the reference model.
    use_math = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int stop;
      logic [7:0] b;
      stop = $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        if (i == stop) rom[i] = '0;
        else if ($urandom_range(0, 9) == 0) rom[i] = 9'($urandom_range(256, 511));
        else rom[i] = 9'($urandom_range(2, 40));
      end
      b      = 8'($urandom_range(0, 255));
      ef_lat = $urandom_range(0, 5);
      mx_lat = $urandom_range(0, 6);
      build_expect(int'(b), pd, nef, nmx);
      run_seq(b, 1'b1, cyc);
      verify_run($sformatf("rand%0d", r), pd, nef, nmx);
    end

    // Every entry valid: the walk must stop at the last address without wrapping.
    for (int i = 0; i < DEPTH; i++) rom[i] = 9'd2;
    ef_lat = 1;
    mx_lat = 1;
    build_expect(3, pd, nef, nmx);
    run_seq(8'd3, 1'b0, cyc);
    verify_run("full_table", DEPTH, DEPTH, DEPTH);

    // Reset during the second WAIT_MX, then a stray mx_done.
    use_math = 1'b0;
    load_vec(vecs[3]);
    f_exp[1] = 2;
    ef_lat   = 0;
    mx_lat   = 6;
    build_expect(10, pd, nef, nmx);
    mx_seen   = 0;
    ef_seen   = 0;
    done_seen = 0;
    @(negedge clk);
    bus.boundary = 8'd10;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (mx_seen < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_2nd_mx", mx_seen, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    ef_q.delete();
    mx_seen   = 0;
    done_seen = 0;
    inject_mx = 1'b1;
    @(negedge clk);
    inject_mx = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_no_mx", mx_seen, 0);
    check("post_rst_no_done", done_seen, 0);
    check("post_rst_idle", bus.busy, 0);
    mx_lat = 0;
    build_expect(10, pd, nef, nmx);
    run_seq(8'd10, 1'b0, cyc);
    verify_run("restart", 2, 2, 5);

    // Modexp never answers.
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    rom[0]   = 9'd2;
    f_exp[0] = 1;
    mx_hang  = 1'b1;
    build_expect(10, pd, nef, nmx);
    mx_seen   = 0;
    done_seen = 0;
    @(negedge clk);
    bus.boundary = 8'd10;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (mx_seen < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hang_mx_issued", mx_seen, 1);
    @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wd_cycles", n, TIMEOUT);
    check("wd_error", bus.error, 1);
    check("wd_done", bus.done, 1);
    repeat (3) @(negedge clk);
    check("wd_error_held", bus.error, 1);
    check("wd_idle", bus.busy, 0);
    mx_hang = 1'b0;
    build_expect(10, pd, nef, nmx);
    run_seq(8'd10, 1'b0, cyc);
    verify_run("after_wd", 1, 1, 1);
`else
    repeat (60) @(negedge clk);
    check("nowd_error", bus.error, 0);
    check("nowd_busy", bus.busy, 1);
    check("nowd_no_done", done_seen, 0);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    mx_hang = 1'b0;
    @(negedge clk);
    check("nowd_recovered", bus.busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
